hazard_stall_unit: RTL and testbench

- Producer-side hazard controller for the 5-stage MIPS pipeline, working alongside the EX-stage forwarding logic.
- Covers the cases forwarding cannot resolve: load-use, branch operands resolved in ID, and the multi-cycle MULT/DIV unit that owns HI/LO.
- Generates the stall and bubble controls for PC, IF/ID and ID/EX.
- Sequences the MULT/DIV busy window with an internal FSM and down-counter.

---
 rtl/hazard_stall_unit.sv | 115 +++++++++++
 tb/tb_hazard_stall_unit.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_unit.sv
// Load-use / ID-branch / MULT-DIV hazard detection with HI/LO busy sequencing.
// Optional per-cause stall statistics are compiled in with HAZARD_STALL_CNT_EN.
module hazard_stall_unit #(
    parameter int unsigned MUL_LAT = 4,
    parameter int unsigned DIV_LAT = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  ID_rs,
    input  logic [4:0]  ID_rt,
    input  logic        ID_UseRs,
    input  logic        ID_UseRt,
    input  logic        ID_Branch,
    input  logic        ID_IsMulDiv,
    input  logic        ID_IsDiv,
    input  logic        ID_ReadHiLo,
    input  logic [4:0]  EX_rd,
    input  logic        EX_RegWrite,
    input  logic        EX_MemRead,
    input  logic [4:0]  MEM_rd,
    input  logic        MEM_MemRead,
    output logic        Stall,
    output logic        IDEX_Bubble,
    output logic        MulDiv_Start,
    output logic        MulDiv_Busy
`ifdef HAZARD_STALL_CNT_EN
    ,
    output logic [31:0] Cnt_LoadUse,
    output logic [31:0] Cnt_Branch,
    output logic [31:0] Cnt_MulDiv
`endif
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [5:0] MUL_INIT = 6'(MUL_LAT - 1);
    localparam logic [5:0] DIV_INIT = 6'(DIV_LAT - 1);

    state_t     state_q, state_d;
    logic [5:0] cnt_q, cnt_d;

    logic ex_match, mem_match;
    logic load_use, br_haz, md_haz, haz_any;

    // r0 is hard-wired to zero, so it can never carry a dependency.
    function automatic logic reg_match(input logic [4:0] r, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic use_rs,
                                       input logic use_rt);
        return (r != 5'd0) && ((use_rs && rs == r) || (use_rt && rt == r));
    endfunction

    always_comb begin
        ex_match  = reg_match(EX_rd,  ID_rs, ID_rt, ID_UseRs, ID_UseRt);
        mem_match = reg_match(MEM_rd, ID_rs, ID_rt, ID_UseRs, ID_UseRt);
        load_use  = EX_MemRead && ex_match;
        br_haz    = ID_Branch && ((EX_RegWrite && ex_match) || (MEM_MemRead && mem_match));
        md_haz    = MulDiv_Busy && (ID_IsMulDiv || ID_ReadHiLo);
        haz_any   = load_use || br_haz || md_haz;
    end

    // Outputs are forced low while reset is held so nothing leaks into the pipe.
    assign Stall        = rst_n && haz_any;
    assign IDEX_Bubble  = Stall;
    assign MulDiv_Start = rst_n && ID_IsMulDiv && !haz_any;
    assign MulDiv_Busy  = (state_q == BUSY);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (MulDiv_Start) begin
                    state_d = BUSY;
                    cnt_d   = ID_IsDiv ? DIV_INIT : MUL_INIT;
                end
            end
            BUSY: begin
                if (cnt_q != 6'd0) cnt_d = cnt_q - 6'd1;
                else               state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 6'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef HAZARD_STALL_CNT_EN
    // Exactly one counter per stalled cycle, attributed by priority load-use > branch > mul/div.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Cnt_LoadUse <= 32'd0;
            Cnt_Branch  <= 32'd0;
            Cnt_MulDiv  <= 32'd0;
        end else begin
            if (load_use && Stall && Cnt_LoadUse != 32'hFFFF_FFFF)
                Cnt_LoadUse <= Cnt_LoadUse + 32'd1;
            if (br_haz && !load_use && Cnt_Branch != 32'hFFFF_FFFF)
                Cnt_Branch <= Cnt_Branch + 32'd1;
            if (md_haz && !load_use && !br_haz && Cnt_MulDiv != 32'hFFFF_FFFF)
                Cnt_MulDiv <= Cnt_MulDiv + 32'd1;
        end
    end
`else
    // Statistics build option off: no counter state.
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Bench for hazard_stall_unit: vector table, hand sequences and a random run
// against a cycle-numbered reference model.
module tb_hazard_stall_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] rs, rt, exrd, memrd;
    logic       ur, ut, br, md, dv, hl, exrw, exmr, memmr;
    logic       stall, bubble, start, busy;
    logic       stall1, bubble1, start1, busy1;
`ifdef HAZARD_STALL_CNT_EN
    logic [31:0] c_lu, c_br, c_md, c1_lu, c1_br, c1_md;
`endif

    int ntests = 0;
    int nfail  = 0;

    always #5 clk = ~clk;

    hazard_stall_unit #(.MUL_LAT(4), .DIV_LAT(32)) u_dut (
        .clk(clk), .rst_n(rst_n), .ID_rs(rs), .ID_rt(rt), .ID_UseRs(ur), .ID_UseRt(ut),
        .ID_Branch(br), .ID_IsMulDiv(md), .ID_IsDiv(dv), .ID_ReadHiLo(hl),
        .EX_rd(exrd), .EX_RegWrite(exrw), .EX_MemRead(exmr), .MEM_rd(memrd),
        .MEM_MemRead(memmr), .Stall(stall), .IDEX_Bubble(bubble),
        .MulDiv_Start(start), .MulDiv_Busy(busy)
`ifdef HAZARD_STALL_CNT_EN
        , .Cnt_LoadUse(c_lu), .Cnt_Branch(c_br), .Cnt_MulDiv(c_md)
`endif
    );

    // Shortest legal latency instance for the one-cycle busy corner.
    hazard_stall_unit #(.MUL_LAT(1), .DIV_LAT(2)) u_lat1 (
        .clk(clk), .rst_n(rst_n), .ID_rs(rs), .ID_rt(rt), .ID_UseRs(ur), .ID_UseRt(ut),
        .ID_Branch(br), .ID_IsMulDiv(md), .ID_IsDiv(dv), .ID_ReadHiLo(hl),
        .EX_rd(exrd), .EX_RegWrite(exrw), .EX_MemRead(exmr), .MEM_rd(memrd),
        .MEM_MemRead(memmr), .Stall(stall1), .IDEX_Bubble(bubble1),
        .MulDiv_Start(start1), .MulDiv_Busy(busy1)
`ifdef HAZARD_STALL_CNT_EN
        , .Cnt_LoadUse(c1_lu), .Cnt_Branch(c1_br), .Cnt_MulDiv(c1_md)
`endif
    );

    typedef struct {
        logic [4:0] rs, rt;
        logic ur, ut, br, md, dv, hl;
        logic [4:0] exrd;
        logic exrw, exmr;
        logic [4:0] memrd;
        logic memmr;
        logic es, est;
    } vec_t;

    vec_t tbl[13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic idle();
        rs = 0; rt = 0; ur = 0; ut = 0; br = 0; md = 0; dv = 0; hl = 0;
        exrd = 0; exrw = 0; exmr = 0; memrd = 0; memmr = 0;
    endtask

    // Reset pulse that starts and ends between two rising edges.
    task automatic reset_dut();
        @(negedge clk);
        idle();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    task automatic set_load_use();
        exmr = 1; exrd = 5'd8; rs = 5'd8; ur = 1;
    endtask

    // Reference model state: cycle index and last cycle of the HI/LO busy window.
    int cyc, busy_end;
    int m_lu, m_br, m_md;

    function automatic logic m_match(input logic [4:0] r);
        return (r != 0) && ((ur && rs == r) || (ut && rt == r));
    endfunction

    initial begin
        rst_n = 1'b0;
        idle();

        // Reset state, with hazardous inputs present.
        set_load_use(); md = 1; hl = 1;
        #3;
        chk("rst_stall", stall, 0);
        chk("rst_bubble", bubble, 0);
        chk("rst_start", start, 0);
        chk("rst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle();

        //           rs rt ur ut br md dv hl exrd rw mr memrd mm  es est
        tbl[0]  = '{8, 0, 1, 0, 0, 0, 0, 0, 8,  0, 1, 0,  0,  1, 0};
        tbl[1]  = '{8, 0, 1, 0, 0, 0, 0, 0, 8,  0, 0, 0,  0,  0, 0};
        tbl[2]  = '{0, 0, 1, 0, 0, 0, 0, 0, 0,  0, 1, 0,  0,  0, 0};
        tbl[3]  = '{0, 8, 0, 0, 0, 0, 0, 0, 8,  0, 1, 0,  0,  0, 0};
        tbl[4]  = '{0, 5, 0, 1, 1, 0, 0, 0, 5,  1, 0, 0,  0,  1, 0};
        tbl[5]  = '{0, 5, 0, 1, 1, 0, 0, 0, 0,  0, 0, 5,  1,  1, 0};
        tbl[6]  = '{0, 5, 0, 1, 1, 0, 0, 0, 0,  0, 0, 6,  1,  0, 0};
        tbl[7]  = '{0, 5, 0, 1, 0, 0, 0, 0, 5,  1, 0, 0,  0,  0, 0};
        tbl[8]  = '{0, 5, 0, 1, 0, 0, 0, 0, 0,  0, 0, 5,  1,  0, 0};
        tbl[9]  = '{0, 0, 1, 1, 1, 0, 0, 0, 0,  1, 0, 0,  1,  0, 0};
        tbl[10] = '{3, 4, 1, 1, 0, 1, 0, 0, 7,  1, 0, 9,  0,  0, 1};
        tbl[11] = '{3, 4, 1, 1, 0, 1, 1, 0, 4,  1, 1, 0,  0,  1, 0};
        tbl[12] = '{0, 0, 0, 0, 0, 0, 0, 1, 0,  0, 0, 0,  0,  0, 0};

        for (int i = 0; i < 13; i++) begin
            reset_dut();
            rs = tbl[i].rs; rt = tbl[i].rt; ur = tbl[i].ur; ut = tbl[i].ut;
            br = tbl[i].br; md = tbl[i].md; dv = tbl[i].dv; hl = tbl[i].hl;
            exrd = tbl[i].exrd; exrw = tbl[i].exrw; exmr = tbl[i].exmr;
            memrd = tbl[i].memrd; memmr = tbl[i].memmr;
            #1;
            chk($sformatf("vec%0d_stall", i), stall, tbl[i].es);
            chk($sformatf("vec%0d_bubble", i), bubble, tbl[i].es);
            chk($sformatf("vec%0d_start", i), start, tbl[i].est);
        end

        // MULT with MFHI held in ID; the latency-1 instance runs alongside.
        reset_dut();
        @(negedge clk);
        md = 1; dv = 0; hl = 1;
        #1;
        chk("mul_start", start, 1);
        chk("mul_c0_stall", stall, 0);
        chk("lat1_start", start1, 1);
        @(negedge clk);
        md = 0;
        #1;
        chk("lat1_busy_c1", busy1, 1);
        for (int c = 1; c <= 5; c++) begin
            if (c > 1) begin
                @(negedge clk);
                #1;
            end
            chk($sformatf("mul_busy_c%0d", c), busy, (c <= 4));
            chk($sformatf("mul_stall_c%0d", c), stall, (c <= 4));
            if (c == 2) chk("lat1_busy_c2", busy1, 0);
        end

        // DIV then a MULT waiting in ID.
        reset_dut();
        @(negedge clk);
        md = 1; dv = 1;
        #1;
        chk("div_start", start, 1);
        for (int c = 1; c <= 32; c++) begin
            @(negedge clk);
            dv = 0;
            #1;
            chk($sformatf("div_busy_c%0d", c), busy, 1);
            chk($sformatf("div_stall_c%0d", c), stall, 1);
            chk($sformatf("div_nostart_c%0d", c), start, 0);
        end
        @(negedge clk);
        #1;
        chk("div_c33_busy", busy, 0);
        chk("div_c33_start", start, 1);
        chk("div_c33_stall", stall, 0);
        for (int c = 34; c <= 38; c++) begin
            @(negedge clk);
            md = 0;
            #1;
            chk($sformatf("mul2_busy_c%0d", c), busy, (c <= 37));
        end

        // Load-use suppresses the start; it fires once the load clears.
        reset_dut();
        @(negedge clk);
        set_load_use(); md = 1;
        #1;
        chk("lu_md_stall", stall, 1);
        chk("lu_md_start", start, 0);
        @(negedge clk);
        exmr = 0;
        #1;
        chk("lu_md_idle", busy, 0);
        chk("lu_md_start2", start, 1);
        @(negedge clk);
        md = 0;
        #1;
        chk("lu_md_busy", busy, 1);

        // Reset during a DIV aborts it at once.
        reset_dut();
        @(negedge clk);
        md = 1; dv = 1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            md = 0; dv = 0;
        end
        set_load_use(); md = 1; hl = 1; br = 1; exrw = 1;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_stall", stall, 0);
        chk("abort_bubble", bubble, 0);
        chk("abort_start", start, 0);
        @(negedge clk);
        idle();
        hl = 1;
        rst_n = 1'b1;
        #1;
        chk("post_rst_stall", stall, 0);
        chk("post_rst_busy", busy, 0);

`ifdef HAZARD_STALL_CNT_EN
        reset_dut();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            set_load_use();
        end
        @(negedge clk);
        idle();
        br = 1; ut = 1; rt = 5'd5; exrw = 1; exrd = 5'd5;
        @(negedge clk);
        idle();
        #1;
        chk("cnt_lu", c_lu, 3);
        chk("cnt_br", c_br, 1);
        chk("cnt_md", c_md, 0);
`endif

        // Random run against the model.
        reset_dut();
        cyc = 0; busy_end = -1;
        m_lu = 0; m_br = 0; m_md = 0;
        for (int n = 0; n < 3000; n++) begin
            logic e_busy, e_lu, e_bh, e_mh, e_st, e_start;
            @(negedge clk);
            rs = 5'($urandom_range(0, 3)); rt = 5'($urandom_range(0, 3));
            exrd = 5'($urandom_range(0, 3)); memrd = 5'($urandom_range(0, 3));
            ur = 1'($urandom); ut = 1'($urandom); br = ($urandom_range(0, 3) == 0);
            exrw = 1'($urandom); exmr = ($urandom_range(0, 3) == 0);
            memmr = ($urandom_range(0, 2) == 0);
            md = ($urandom_range(0, 5) == 0); dv = 1'($urandom); hl = ($urandom_range(0, 2) == 0);
            e_busy  = (cyc <= busy_end);
            e_lu    = exmr && m_match(exrd);
            e_bh    = br && ((exrw && m_match(exrd)) || (memmr && m_match(memrd)));
            e_mh    = e_busy && (md || hl);
            e_st    = e_lu || e_bh || e_mh;
            e_start = md && !e_st;
            #1;
            chk("rnd_stall", stall, e_st);
            chk("rnd_bubble", bubble, e_st);
            chk("rnd_start", start, e_start);
            chk("rnd_busy", busy, e_busy);
            if (e_start) busy_end = cyc + (dv ? 32 : 4);
            if (e_lu) m_lu++;
            else if (e_bh) m_br++;
            else if (e_mh) m_md++;
            cyc++;
        end
        @(negedge clk);
        idle();
`ifdef HAZARD_STALL_CNT_EN
        #1;
        chk("rnd_cnt_lu", c_lu, m_lu);
        chk("rnd_cnt_br", c_br, m_br);
        chk("rnd_cnt_md", c_md, m_md);
`endif

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
